// File: rtl/sseg_pkg.sv
// Shared MAX7219 register map, frame width, FSM state type and frame lookup
// for the max7219_tx driver.
package sseg_pkg;

    localparam logic [7:0] ADDR_DIGIT0    = 8'h01;
    localparam logic [7:0] ADDR_DECODE    = 8'h09;
    localparam logic [7:0] ADDR_INTENSITY = 8'h0A;
    localparam logic [7:0] ADDR_SCANLIM   = 8'h0B;
    localparam logic [7:0] ADDR_SHUTDN    = 8'h0C;

    localparam int FRAME_W = 16;

    // Frame index space: 0..4 are the init frames, 5..12 are digits 0..7.
    localparam logic [3:0] FIRST_DIGIT_IDX = 4'd5;
    localparam logic [3:0] LAST_IDX        = 4'd12;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        GAP,
        DONE
    } state_t;

    function automatic logic [FRAME_W-1:0] frame_word(
        input logic [3:0]  idx,
        input logic [63:0] seg,
        input logic [3:0]  intensity
    );
        logic [3:0] g;
        g = idx - FIRST_DIGIT_IDX;
        case (idx)
            4'd0:    frame_word = {ADDR_SHUTDN, 8'h00};
            4'd1:    frame_word = {ADDR_DECODE, 8'h00};
            4'd2:    frame_word = {ADDR_INTENSITY, 4'h0, intensity};
            4'd3:    frame_word = {ADDR_SCANLIM, 8'h07};
            4'd4:    frame_word = {ADDR_SHUTDN, 8'h01};
            default: frame_word = {ADDR_DIGIT0 + {5'd0, g[2:0]}, seg[g[2:0]*8 +: 8]};
        endcase
    endfunction

endpackage

// File: rtl/spi_frame_tx.sv
// 16-bit MSB-first serializer with SCLK divider. One frame is
// SETUP + 16 x (SHIFT_HI + SHIFT_LO) + GAP, each phase CLK_DIV clk cycles.
module spi_frame_tx
    import sseg_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [FRAME_W-1:0] frame,
    output logic               ready,
    output logic               cs_n,
    output logic               sclk,
    output logic               mosi,
    output state_t             state
);

    // Handshake: a frame is taken when load && ready. ready is high in IDLE
    // and in the last GAP cycle, so frames chain with no idle cycle between.
    localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);

    state_t               state_d;
    logic [7:0]           div_cnt;
    logic [3:0]           bit_idx;
    logic [FRAME_W-1:0]   shreg;
    logic                 phase_end;

    assign phase_end = (div_cnt == 8'd0);
    assign ready     = (state == IDLE) || ((state == GAP) && phase_end);

    always_comb begin
        state_d = state;
        case (state)
            IDLE:     if (load) state_d = SETUP;
            SETUP:    if (phase_end) state_d = SHIFT_HI;
            SHIFT_HI: if (phase_end) state_d = SHIFT_LO;
            SHIFT_LO: if (phase_end) state_d = (bit_idx == 4'd0) ? GAP : SHIFT_HI;
            GAP:      if (phase_end) state_d = load ? SETUP : IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            div_cnt <= DIV_RELOAD;
            bit_idx <= 4'd15;
            shreg   <= '0;
        end else begin
            state <= state_d;
            if ((state_d != state) || (state == IDLE))
                div_cnt <= DIV_RELOAD;
            else
                div_cnt <= div_cnt - 8'd1;

            // Shifting in a zero on each HI->LO leaves mosi low after bit 0.
            if (load && ready) begin
                shreg   <= frame;
                bit_idx <= 4'd15;
            end else if ((state == SHIFT_HI) && (state_d == SHIFT_LO)) begin
                shreg <= {shreg[FRAME_W-2:0], 1'b0};
            end else if ((state == SHIFT_LO) && (state_d == SHIFT_HI)) begin
                bit_idx <= bit_idx - 4'd1;
            end
        end
    end

    assign cs_n = !((state == SETUP) || (state == SHIFT_HI) || (state == SHIFT_LO));
    assign sclk = (state == SHIFT_HI);
    assign mosi = !cs_n && shreg[FRAME_W-1];

endmodule

// File: rtl/max7219_tx.sv
// MAX7219 display updater: sends eight digit frames per start request.
// Define MAX7219_INIT_EN to prepend the five-frame init sequence after reset.
module max7219_tx
    import sseg_pkg::*;
#(
    parameter int         CLK_DIV   = 4,
    parameter logic [3:0] INTENSITY = 4'h8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] seg_data,
    input  logic        start,
    output logic        cs_n,
    output logic        sclk,
    output logic        mosi,
    output logic        busy,
    output logic        done
);

    logic               busy_q;
    logic               done_q;
    logic               init_pend;
    logic               accept;
    logic               load;
    logic               ready;
    logic               frame_end;
    logic [3:0]         frame_idx;
    logic [3:0]         first_idx;
    logic [3:0]         load_idx;
    logic [63:0]        data_q;
    logic [63:0]        src;
    logic [FRAME_W-1:0] frame;
    state_t             frame_state;

    assign accept    = start && !busy_q;
    assign frame_end = ready && (frame_state == GAP);
    assign first_idx = init_pend ? 4'd0 : FIRST_DIGIT_IDX;
    assign load      = accept || (busy_q && frame_end && (frame_idx != LAST_IDX));
    assign load_idx  = accept ? first_idx : frame_idx + 4'd1;
    // The first frame goes out before data_q is written, so read it live.
    assign src       = busy_q ? data_q : seg_data;
    assign frame     = frame_word(load_idx, src, INTENSITY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            frame_idx <= 4'd0;
            data_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                data_q    <= seg_data;
                frame_idx <= first_idx;
                busy_q    <= 1'b1;
            end else if (busy_q && frame_end) begin
                if (frame_idx == LAST_IDX) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    frame_idx <= frame_idx + 4'd1;
                end
            end
        end
    end

`ifdef MAX7219_INIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            init_pend <= 1'b1;
        else if (accept)
            init_pend <= 1'b0;
    end
`else
    assign init_pend = 1'b0;
`endif

    spi_frame_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_spi (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .frame (frame),
        .ready (ready),
        .cs_n  (cs_n),
        .sclk  (sclk),
        .mosi  (mosi),
        .state (frame_state)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_max7219_tx.sv
// Directed bench for max7219_tx: frame capture on sclk rising edges,
// expected-frame queue, latency and reset checks.
module tb_max7219_tx;

    localparam int CLK_DIV   = 4;
    localparam int FRAME_CYC = 34 * CLK_DIV;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        start    = 1'b0;
    logic [63:0] seg_data = '0;
    logic        cs_n, sclk, mosi, busy, done;

    always #5 clk = ~clk;

    max7219_tx #(
        .CLK_DIV   (CLK_DIV),
        .INTENSITY (4'h8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .seg_data (seg_data),
        .start    (start),
        .cs_n     (cs_n),
        .sclk     (sclk),
        .mosi     (mosi),
        .busy     (busy),
        .done     (done)
    );

    int          err_cnt = 0;
    int          chk_cnt = 0;
    logic [15:0] exp_q[$];
    bit          init_pend_tb = 1'b1;
    bit          mon_en = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Frame monitor: shift mosi on each sclk rise inside cs_n=0, score on cs_n rise.
    logic [15:0] mon_word  = '0;
    int          mon_bits  = 0;
    logic        prev_sclk = 1'b0;
    logic        prev_cs   = 1'b1;

    always @(negedge clk) begin
        if (mon_en) begin
            if (!cs_n && sclk && !prev_sclk) begin
                mon_word = {mon_word[14:0], mosi};
                mon_bits++;
            end
            if (cs_n && !prev_cs) begin
                check("cs_rise_sclk_low", {31'd0, sclk}, 32'd0);
                check("bits_per_frame", mon_bits, 32'd16);
                if (exp_q.size() == 0)
                    check("unexpected_frame_q_size", exp_q.size(), 32'd1);
                else
                    check("frame", {16'd0, mon_word}, {16'd0, exp_q.pop_front()});
                mon_bits = 0;
                mon_word = '0;
            end
        end else begin
            mon_bits = 0;
            mon_word = '0;
        end
        prev_sclk = sclk;
        prev_cs   = cs_n;
    end

    task automatic push_init();
`ifdef MAX7219_INIT_EN
        if (init_pend_tb) begin
            exp_q.push_back(16'h0C00);
            exp_q.push_back(16'h0900);
            exp_q.push_back(16'h0A08);
            exp_q.push_back(16'h0B07);
            exp_q.push_back(16'h0C01);
        end
`endif
        init_pend_tb = 1'b0;
    endtask

    task automatic push_update(input logic [63:0] d);
        push_init();
        for (int g = 0; g < 8; g++)
            exp_q.push_back({8'(g + 1), d[g*8 +: 8]});
    endtask

    task automatic run_update(input logic [63:0] d, input bit disturb);
        int nf;
        int cyc;
        nf = exp_q.size();
        @(negedge clk);
        seg_data = d;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        cyc = 0;
        while (!done && cyc < nf * FRAME_CYC + 100) begin
            if (disturb && cyc < nf * FRAME_CYC - 20) begin
                start    = ((cyc % 150) == 7);
                seg_data = {$urandom, $urandom};
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("done_latency", cyc, nf * FRAME_CYC);
        check("busy_low_in_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("frames_left", exp_q.size(), 32'd0);
        repeat (10) @(negedge clk);
        check("idle_after_update", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_done(input int budget, input string tag);
        int cyc;
        cyc = 0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    initial begin
        logic [63:0] d;
        int cyc;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_cs_n", {31'd0, cs_n}, 32'd1);
        check("rst_sclk", {31'd0, sclk}, 32'd0);
        check("rst_mosi", {31'd0, mosi}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // First update: hand-computed digit frames (init frames first when compiled in)
        push_init();
        exp_q.push_back(16'h017E);
        exp_q.push_back(16'h0279);
        exp_q.push_back(16'h0333);
        exp_q.push_back(16'h045B);
        exp_q.push_back(16'h055F);
        exp_q.push_back(16'h0670);
        exp_q.push_back(16'h077F);
        exp_q.push_back(16'h087B);
        run_update(64'h7B7F705F5B33797E, 1'b0);

        // Second update with start pulses and seg_data churn while busy
        push_update(64'h0123456789ABCDEF);
        run_update(64'h0123456789ABCDEF, 1'b1);

        // Boundary patterns
        push_update(64'hFFFFFFFFFFFFFFFF);
        run_update(64'hFFFFFFFFFFFFFFFF, 1'b0);
        push_update(64'h0000000000000000);
        run_update(64'h0000000000000000, 1'b0);

        // Start held high: back-to-back updates
        d = 64'h80402010_08040201;
        push_update(d);
        push_update(d);
        @(negedge clk);
        seg_data = d;
        start    = 1'b1;
        wait_done(8 * FRAME_CYC + 50, "b2b_first_done");
        check("b2b_busy_in_done", {31'd0, busy}, 32'd0);
        check("b2b_cs_high_in_done", {31'd0, cs_n}, 32'd1);
        @(negedge clk);
        check("b2b_cs_fall_after_done", {31'd0, cs_n}, 32'd0);
        check("b2b_busy_second", {31'd0, busy}, 32'd1);
        start = 1'b0;
        wait_done(8 * FRAME_CYC + 50, "b2b_second_done");
        @(negedge clk);
        check("b2b_frames_left", exp_q.size(), 32'd0);
        repeat (5) @(negedge clk);

        // Reset mid-frame while sclk and mosi are high
        push_update(64'h1122334455667788);
        @(negedge clk);
        seg_data = 64'h1122334455667788;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(sclk && mosi) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("reached_shift_hi", {30'd0, sclk, mosi}, 32'd3);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("midrst_cs_n", {31'd0, cs_n}, 32'd1);
        check("midrst_sclk", {31'd0, sclk}, 32'd0);
        check("midrst_mosi", {31'd0, mosi}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        exp_q.delete();
        init_pend_tb = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // First update after reset re-arms init when compiled in
        push_update(64'h5A5AA5A5C3C33C3C);
        run_update(64'h5A5AA5A5C3C33C3C, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
